// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : op/state encodings and helpers shared by multicycle_alu
// Rev 1.0 : initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_PASSB = 4'b0110,
        ALU_SLTU  = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_RSVD  = 4'b1011,
        ALU_MUL   = 4'b1100,
        ALU_MULHU = 4'b1101,
        ALU_DIVU  = 4'b1110,
        ALU_REMU  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// alu_muldiv_iter : radix-2 shift-add multiplier / restoring divider (unsigned)
// Rev 1.0 : initial release
// ============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    alu_op_e               op_q, op_d;
    logic                  run_q, run_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic                  w_is_mul;
    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH:0]   w_rem_sub;

    assign w_is_mul = (op_q == ALU_MUL) || (op_q == ALU_MULHU);

    // {hi,lo} is the product for multiply and {remainder,quotient} for divide
    always_comb begin
        w_addend  = lo_q[0] ? m_q : '0;
        w_sum     = {1'b0, hi_q} + {1'b0, w_addend};
        w_rem_sh  = {hi_q, lo_q[DATA_WIDTH-1]};
        w_rem_sub = w_rem_sh - {1'b0, m_q};
        op_d      = op_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start) begin
            op_d  = op;
            run_d = 1'b1;
            cnt_d = CNT_W'(DATA_WIDTH - 1);
            hi_d  = '0;
            if ((op == ALU_MUL) || (op == ALU_MULHU)) begin
                m_d  = a;
                lo_d = b;
            end else begin
                m_d  = b;
                lo_d = a;
            end
        end else if (run_q) begin
            if (w_is_mul) begin
                hi_d = w_sum[DATA_WIDTH:1];
                lo_d = {w_sum[0], lo_q[DATA_WIDTH-1:1]};
            // remainder stays below the divisor, so the top bit is a pure borrow
            end else if (!w_rem_sub[DATA_WIDTH]) begin
                hi_d = w_rem_sub[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_d = w_rem_sh[DATA_WIDTH-1:0];
                lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign done   = run_q && (cnt_q == '0);
    assign result = ((op_q == ALU_MUL) || (op_q == ALU_DIVU)) ? lo_d : hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= ALU_ADD;
            run_q <= 1'b0;
            cnt_q <= '0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            op_q  <= op_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// multicycle_alu : RV32I ALU with optional iterative mul/div (ALU_MULDIV_EN),
//                  valid/ready handshakes on both sides.
// Rev 1.0 : initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_op1,
    input  logic [DATA_WIDTH-1:0] alu_op2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic                  illegal
);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;

    alu_op_e               w_op;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_sc_result;
    logic                  w_sc_illegal;
    logic                  w_start;
    logic                  w_mc_done;
    logic [DATA_WIDTH-1:0] w_mc_result;

    assign w_op    = alu_op_e'(alu_ctrl);
    assign w_shamt = alu_op2[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
    assign w_start = in_valid && (state_q == IDLE) && is_muldiv(w_op);

    alu_muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .op     (w_op),
        .a      (alu_op1),
        .b      (alu_op2),
        .done   (w_mc_done),
        .result (w_mc_result)
    );
`else
    assign w_start     = 1'b0;
    assign w_mc_done   = 1'b0;
    assign w_mc_result = '0;
`endif

    // Mul/div encodings land in default: illegal when the engine is absent,
    // never selected when it is present.
    always_comb begin
        w_sc_result  = '0;
        w_sc_illegal = 1'b0;
        case (w_op)
            ALU_ADD:   w_sc_result = alu_op1 + alu_op2;
            ALU_SUB:   w_sc_result = alu_op1 - alu_op2;
            ALU_AND:   w_sc_result = alu_op1 & alu_op2;
            ALU_OR:    w_sc_result = alu_op1 | alu_op2;
            ALU_XOR:   w_sc_result = alu_op1 ^ alu_op2;
            ALU_SLT:   w_sc_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
            ALU_SLTU:  w_sc_result = {{(DATA_WIDTH-1){1'b0}}, (alu_op1 < alu_op2)};
            ALU_PASSB: w_sc_result = alu_op2;
            ALU_SLL:   w_sc_result = alu_op1 << w_shamt;
            ALU_SRL:   w_sc_result = alu_op1 >> w_shamt;
            ALU_SRA:   w_sc_result = $unsigned($signed(alu_op1) >>> w_shamt);
            default:   w_sc_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (w_start) begin
                        state_d = BUSY;
                    end else begin
                        state_d   = DONE;
                        result_d  = w_sc_result;
                        zero_d    = (w_sc_result == '0);
                        illegal_d = w_sc_illegal;
                    end
                end
            end
            BUSY: begin
                if (w_mc_done) begin
                    state_d   = DONE;
                    result_d  = w_mc_result;
                    zero_d    = (w_mc_result == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// tb_multicycle_alu : randomized + directed checks of multicycle_alu against
//                     a behavioural reference model (honours ALU_MULDIV_EN)
// Rev 1.0 : initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         illegal;

    int checks   = 0;
    int failures = 0;

    multicycle_alu #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operation rules
    function automatic void ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic il, output int lat);
        logic [2*W-1:0] p;
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  r = b;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $unsigned($signed(a) >>> b[4:0]);
            4'd11: il = 1'b1;
            4'd12: if (MD) begin r = p[W-1:0];   lat = W + 1; end else il = 1'b1;
            4'd13: if (MD) begin r = p[2*W-1:W]; lat = W + 1; end else il = 1'b1;
            4'd14: if (MD) begin r = (b == 0) ? '1 : a / b; lat = W + 1; end else il = 1'b1;
            default: if (MD) begin r = (b == 0) ? a : a % b; lat = W + 1; end else il = 1'b1;
        endcase
    endfunction

    // Cycle-level expectation: idle / waiting-for-result / holding-result
    logic         m_valid;
    int           m_wait;
    logic [W-1:0] m_res;
    logic         m_ill;
    logic         m_zero;
    logic [W-1:0] t_r;
    logic         t_i;
    int           t_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_wait  = 0;
            m_res   = '0;
            m_ill   = 1'b0;
            m_zero  = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_wait != 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            ref_alu(alu_ctrl, alu_op1, alu_op2, t_r, t_i, t_l);
            m_res   = t_r;
            m_ill   = t_i;
            m_zero  = (t_r == '0);
            m_wait  = t_l - 1;
            m_valid = (t_l == 1);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc.in_ready", 32'(in_ready), 32'(!m_valid && m_wait == 0));
            chk("cyc.out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid && out_valid) begin
                chk("cyc.result", alu_result, m_res);
                chk("cyc.zero", 32'(zero), 32'(m_zero));
                chk("cyc.illegal", 32'(illegal), 32'(m_ill));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again
    task automatic run_op(input string nm, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ei, input int elat, input int hold);
        int lat;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        alu_op1  = a;
        alu_op2  = b;
        @(negedge clk);
        in_valid = 1'b0;
        alu_op1  = $urandom;
        alu_op2  = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, ".latency"}, 32'(lat), 32'(elat));
        chk({nm, ".result"}, alu_result, er);
        chk({nm, ".zero"}, 32'(zero), 32'(er == '0));
        chk({nm, ".illegal"}, 32'(illegal), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            alu_ctrl = 4'($urandom);
            alu_op1  = $urandom;
            alu_op2  = $urandom;
            @(negedge clk);
            chk({nm, ".held"}, alu_result, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]   c;
        logic [W-1:0] a, b, er;
        logic         ei;
        int           el;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", alu_result, 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1, 0);
        run_op("sub_zero", 4'h1, 32'd5, 32'd5, 32'h0, 1'b0, 1, 1);
        run_op("slt", 4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 0);
        run_op("sltu", 4'h7, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
        run_op("sra", 4'hA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0);
        run_op("passb", 4'h6, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1, 0);
        run_op("rsvd", 4'hB, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 1, 0);
        run_op("mul", 4'hC, 32'h0000_FFFF, 32'h0001_0001, MD ? 32'hFFFF_FFFF : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("mulhu", 4'hD, 32'hFFFF_FFFF, 32'h2, MD ? 32'h1 : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("divu", 4'hE, 32'd100, 32'd7, MD ? 32'd14 : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("remu", 4'hF, 32'd100, 32'd7, MD ? 32'd2 : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("divu0", 4'hE, 32'hCAFE_0001, 32'd0, MD ? 32'hFFFF_FFFF : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("remu0", 4'hF, 32'd9, 32'd0, MD ? 32'd9 : 32'h0, !MD, MD ? 33 : 1, 0);
        run_op("bp_hold", 4'h3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1, 10);
        run_op("bp_next", 4'h8, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1, 0);

`ifdef ALU_MULDIV_EN
        in_valid = 1'b1;
        alu_ctrl = 4'hC;
        alu_op1  = 32'd3;
        alu_op2  = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", alu_result, 32'd0);
        chk("abort.zero", 32'(zero), 32'd0);
        chk("abort.illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_abort", 4'h4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            c = 4'($urandom);
            a = pick();
            b = pick();
            ref_alu(c, a, b, er, ei, el);
            run_op("rand", c, a, b, er, ei, el, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
